color_bank_master: RTL and testbench
====================================

COLOR_BANK_MASTER -- requirements
Module: color_bank_master

Interface
REQ-001 SHALL: clock  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL: _reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: req_valid  input  1  host request present.
REQ-004 SHALL: req_ready  output  1  high only in IDLE; a transfer is accepted when req_valid & req_ready at a rising edge.
REQ-005 SHALL: req_write  input  1  1 = write cycle, 0 = read cycle.
REQ-006 SHALL: req_bank  input  7  [5:0] SRAM bank, [6] nibble lane (0 = low byte lane, 1 = high byte lane).
REQ-007 SHALL: req_addr  input  10  color RAM offset; req_data  input  4  write nibble.
REQ-008 SHALL: rsp_valid  output  1  one-cycle completion pulse; rsp_data  output  4  read nibble; rsp_err  output  1  request targeted a bank register.
REQ-009 SHALL: address_color  output  10; data_color  inout  4; _ce_color  output  1; _we_color  output  1; phi  output  1  (all are the color RAM bus driven towards the banking responder).

Function
REQ-010 SHALL: states IDLE, SET_LO, SET_HI, ACCESS, DONE; each of SET_LO/SET_HI/ACCESS is one 3-cycle bus cycle with phases SETUP, STROBE, HOLD.
REQ-011 SHALL: SETUP -- _ce_color=0, phi=1, address driven, _we_color=1; write data driven on data_color, read leaves data_color Z.
REQ-012 SHALL: STROBE -- write: _we_color=0; read: _we_color=1, data_color sampled into rsp_data at the rising edge ending STROBE.
REQ-013 SHALL: HOLD -- _we_color=1, _ce_color=0, phi=1, address/data held; on exit _ce_color=1, phi=0, data_color Z, address_color held.
REQ-014 SHALL: SET_LO writes req_bank[3:0] to address 10'h3FE; SET_HI writes {1'b0, req_bank[6:4]} to 10'h3FF; ACCESS reads or writes req_addr.
REQ-015 SHALL: request fields captured at acceptance; inputs ignored until the next IDLE.
REQ-016 SHALL: sequence IDLE -> SET_LO -> SET_HI -> ACCESS -> DONE -> IDLE; rsp_valid=1 for the single DONE cycle; uncached latency acceptance->rsp_valid = 10 cycles.
REQ-017 SHALL: req_addr of 10'h3FE or 10'h3FF -> ACCESS still executed, rsp_err=1 in DONE, bank cache (REQ-022) invalidated.
REQ-018 SHALL: rsp_data holds its last read value until the next read; rsp_err=0 outside DONE.
REQ-019 SHALL: data_color never driven while _we_color=1 during a read, and never driven outside SETUP/STROBE/HOLD of a write.

Reset
REQ-020 SHALL: _reset low -> immediately state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, address_color=0, data_color Z, _ce_color=1, _we_color=1, phi=0, bank cache invalid; any bus cycle in progress is abandoned.
REQ-021 SHALL: first request after reset always performs both bank writes.

Configuration
REQ-022 SHALL: macro BANK_CACHE_EN defined -> 7-bit cache of last programmed bank plus valid bit; SET_LO skipped if cached [3:0] matches, SET_HI skipped if cached [6:4] matches; cache updated after each completed bank write; full hit latency = 4 cycles.
REQ-023 SHALL: BANK_CACHE_EN undefined -> no cache logic; every request performs SET_LO and SET_HI.

Verification
REQ-024 SHALL: reset, write bank 7'h45 addr 10'h123 data 4'hA -> bus writes 4'h5@3FE, 4'h4@3FF, 4'hA@123; rsp_valid 10 cycles after accept, rsp_err=0.
REQ-025 SHALL: read bank 7'h45 addr 10'h123 with responder returning 4'hA -> rsp_data=4'hA; data_color Z from master throughout ACCESS.
REQ-026 SHALL: BANK_CACHE_EN, two back-to-back requests bank 7'h45 -> second shows no 3FE/3FF cycles, latency 4; then bank 7'h05 -> only 3FF cycle, latency 7.
REQ-027 SHALL: write to addr 10'h3FF -> rsp_err=1 for one cycle; next request (bank unchanged) repeats both bank writes.
REQ-028 SHALL: assert _reset during STROBE of SET_HI -> _we_color=1, _ce_color=1, phi=0, data_color Z same cycle; after release req_ready=1 and next request rewrites 3FE and 3FF.
REQ-029 SHALL: every write strobe checked: phi=1 and data_color stable at falling and rising edge of _we_color.

Source files
------------

// File: rtl/color_bank_master.sv
// Color RAM bank master: programs bank registers 3FE/3FF over a 3-phase bus, then runs the host access.
// Optional macro BANK_CACHE_EN keeps the last programmed bank and skips bank writes that would not change it.
module color_bank_master (
  input  logic       clock,
  input  logic       _reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_bank,
  input  logic [9:0] req_addr,
  input  logic [3:0] req_data,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_err,
  output logic [9:0] address_color,
  inout  wire  [3:0] data_color,
  output logic       _ce_color,
  output logic       _we_color,
  output logic       phi
);
  typedef enum logic [2:0] {IDLE, SET_LO, SET_HI, ACCESS, DONE} state_e;
  typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_e;

  localparam logic [9:0] BANK_LO_ADDR = 10'h3FE;
  localparam logic [9:0] BANK_HI_ADDR = 10'h3FF;

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic       req_wr_q, req_err_q;
  logic [6:0] req_bank_q;
  logic [9:0] req_addr_q;
  logic [3:0] req_data_q;
  logic [9:0] bus_addr_q, bus_addr_d;
  logic [3:0] bus_dat_q, bus_dat_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       accept, need_lo, need_hi, start_bus, bus_oe;
  logic [6:0] bank_sel;
  logic [9:0] addr_sel;
  logic [3:0] data_sel;

  assign accept   = (state_q == IDLE) && req_valid;
  // Leaving IDLE the request is captured on this same edge, so the live inputs are used.
  assign bank_sel = (state_q == IDLE) ? req_bank : req_bank_q;
  assign addr_sel = (state_q == IDLE) ? req_addr : req_addr_q;
  assign data_sel = (state_q == IDLE) ? req_data : req_data_q;

`ifdef BANK_CACHE_EN
  logic [6:0] cache_bank_q, cache_bank_d;
  logic       cache_vld_q, cache_vld_d;

  assign need_lo = !cache_vld_q || (cache_bank_q[3:0] != bank_sel[3:0]);
  assign need_hi = !cache_vld_q || (cache_bank_q[6:4] != bank_sel[6:4]);

  // Valid is only set by a completed SET_HI; an invalid cache always forces both writes.
  always_comb begin
    cache_bank_d = cache_bank_q;
    cache_vld_d  = cache_vld_q;
    if (phase_q == HOLD) begin
      case (state_q)
        SET_LO: cache_bank_d[3:0] = req_bank_q[3:0];
        SET_HI: begin
          cache_bank_d[6:4] = req_bank_q[6:4];
          cache_vld_d       = 1'b1;
        end
        ACCESS: if (req_err_q) cache_vld_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      cache_bank_q <= '0;
      cache_vld_q  <= 1'b0;
    end else begin
      cache_bank_q <= cache_bank_d;
      cache_vld_q  <= cache_vld_d;
    end
  end
`else
  assign need_lo = 1'b1;
  assign need_hi = 1'b1;
`endif

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q <= IDLE;
      phase_q <= SETUP;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        phase_d = SETUP;
        if (req_valid) state_d = need_lo ? SET_LO : (need_hi ? SET_HI : ACCESS);
      end
      SET_LO, SET_HI, ACCESS: begin
        if (phase_q == HOLD) begin
          phase_d = SETUP;
          case (state_q)
            SET_LO:  state_d = need_hi ? SET_HI : ACCESS;
            SET_HI:  state_d = ACCESS;
            default: state_d = DONE;
          endcase
        end else begin
          phase_d = (phase_q == SETUP) ? STROBE : HOLD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    _ce_color = 1'b1;
    _we_color = 1'b1;
    phi       = 1'b0;
    bus_oe    = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      SET_LO, SET_HI, ACCESS: begin
        _ce_color = 1'b0;
        phi       = 1'b1;
        bus_oe    = (state_q != ACCESS) || req_wr_q;
        _we_color = !(bus_oe && (phase_q == STROBE));
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = req_err_q;
      end
      default: ;
    endcase
  end

  // Address and write data are latched once per bus cycle so they stay put through HOLD and after.
  assign start_bus = (state_d != state_q) &&
                     ((state_d == SET_LO) || (state_d == SET_HI) || (state_d == ACCESS));

  always_comb begin
    bus_addr_d = bus_addr_q;
    bus_dat_d  = bus_dat_q;
    if (start_bus) begin
      case (state_d)
        SET_LO: begin
          bus_addr_d = BANK_LO_ADDR;
          bus_dat_d  = bank_sel[3:0];
        end
        SET_HI: begin
          bus_addr_d = BANK_HI_ADDR;
          bus_dat_d  = {1'b0, bank_sel[6:4]};
        end
        default: begin
          bus_addr_d = addr_sel;
          bus_dat_d  = data_sel;
        end
      endcase
    end
  end

  always_comb begin
    rsp_data_d = rsp_data_q;
    if ((state_q == ACCESS) && (phase_q == STROBE) && !req_wr_q) rsp_data_d = data_color;
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      req_wr_q   <= 1'b0;
      req_err_q  <= 1'b0;
      req_bank_q <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      bus_addr_q <= '0;
      bus_dat_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        req_wr_q   <= req_write;
        req_err_q  <= (req_addr[9:1] == 9'h1FF);
        req_bank_q <= req_bank;
        req_addr_q <= req_addr;
        req_data_q <= req_data;
      end
      bus_addr_q <= bus_addr_d;
      bus_dat_q  <= bus_dat_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign address_color = bus_addr_q;
  assign rsp_data      = rsp_data_q;
  assign data_color    = bus_oe ? bus_dat_q : 4'bz;

endmodule

// File: tb/tb_color_bank_master.sv
// Directed bench for color_bank_master: logs every bus write strobe, models a read responder,
// and checks latency, bank programming, error, Z discipline and mid-cycle reset (BANK_CACHE_EN aware).
module tb_color_bank_master;

`ifdef BANK_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       _reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_bank = '0;
  logic [9:0] req_addr = '0;
  logic [3:0] req_data = '0;
  logic       req_ready, rsp_valid, rsp_err;
  logic [3:0] rsp_data;
  logic [9:0] address_color;
  logic       _ce_color, _we_color, phi;
  wire  [3:0] data_color;

  int n_chk = 0;
  int n_fail = 0;

  color_bank_master dut (
    .clock(clock), ._reset(_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .address_color(address_color), .data_color(data_color),
    ._ce_color(_ce_color), ._we_color(_we_color), .phi(phi)
  );

  always #5 clock = ~clock;

  // An undriven bus reads as 4'hF, which is how "master not driving" is observed.
  pullup pu_dc (data_color);

  // Bus phase tracker and read responder: drives only during STROBE of a read cycle.
  logic [1:0] ph;
  logic [3:0] resp_val = 4'h0;
  always @(posedge clock or negedge _reset) begin
    if (!_reset)         ph <= 2'd0;
    else if (!_ce_color) ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
    else                 ph <= 2'd0;
  end
  assign data_color = (!_ce_color && _we_color && ph == 2'd1) ? resp_val : 4'bz;

  // Write strobe log: {addr,data} at the falling edge, plus whether the strobe was well formed.
  bit          armed = 1'b0;
  logic [9:0]  fa;
  logic [3:0]  fd;
  logic        fphi;
  logic [13:0] wl_q[$];
  bit          wl_ok[$];
  always @(negedge _we_color) begin
    fa = address_color; fd = data_color; fphi = phi;
  end
  always @(posedge _we_color) begin
    if (armed && _reset) begin
      wl_q.push_back({fa, fd});
      wl_ok.push_back(fphi === 1'b1 && phi === 1'b1 && fd === data_color && fa === address_color);
    end
  end

  int zi_chk = 0, zi_viol = 0, zw_chk = 0, zw_viol = 0;
  bit zwatch = 1'b0;
  always @(negedge clock) begin
    if (armed) begin
      if (_ce_color) begin
        zi_chk++;
        if (data_color !== 4'hF) zi_viol++;
      end else if (zwatch && _we_color && ph != 2'd1 && address_color == 10'h123) begin
        zw_chk++;
        if (data_color !== 4'hF) zw_viol++;
      end
    end
  end

  task automatic run_req(input logic w, input logic [6:0] b, input logic [9:0] a, input logic [3:0] d,
                         output int lat, output logic err, output logic [3:0] rd);
    int guard;
    guard = 0;
    wl_q.delete(); wl_ok.delete();
    @(negedge clock);
    while (!req_ready && guard < 20) begin @(negedge clock); guard++; end
    req_valid = 1'b1; req_write = w; req_bank = b; req_addr = a; req_data = d;
    @(negedge clock);
    req_valid = 1'b0; req_write = ~w; req_bank = ~b; req_addr = ~a; req_data = ~d;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clock); lat++; end
    err = rsp_err;
    rd  = rsp_data;
  endtask

  task automatic test_reset;
    _reset = 1'b0;
    repeat (3) @(negedge clock);
    n_chk++;
    if ({req_ready, rsp_valid, rsp_err, rsp_data, address_color, data_color, _ce_color, _we_color, phi}
        !== {1'b1, 1'b0, 1'b0, 4'h0, 10'h000, 4'hF, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rd=%h a=%h d=%h ce=%b we=%b phi=%b want 1 0 0 0 000 f 1 1 0",
               req_ready, rsp_valid, rsp_err, rsp_data, address_color, data_color, _ce_color, _we_color, phi);
    end
    _reset = 1'b1;
    armed  = 1'b1;
    @(negedge clock);
    n_chk++;
    if ({req_ready, rsp_valid, _ce_color, phi} !== 4'b1010) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 1010", {req_ready, rsp_valid, _ce_color, phi});
    end
  endtask

  task automatic test_write;
    int lat; logic err; logic [3:0] rd;
    logic [13:0] exp_w [3];
    exp_w = '{{10'h3FE, 4'h5}, {10'h3FF, 4'h4}, {10'h123, 4'hA}};
    run_req(1'b1, 7'h45, 10'h123, 4'hA, lat, err, rd);
    n_chk++; if (lat != 10) begin n_fail++; $display("FAIL write_latency: got %0d want 10", lat); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b want 0", err); end
    n_chk++; if (wl_q.size() != 3) begin n_fail++; $display("FAIL write_count: got %0d want 3", wl_q.size()); end
    for (int i = 0; i < 3 && i < wl_q.size(); i++) begin
      n_chk++;
      if (wl_q[i] !== exp_w[i] || !wl_ok[i]) begin
        n_fail++; $display("FAIL write_bus[%0d]: got %h ok=%b want %h ok=1", i, wl_q[i], wl_ok[i], exp_w[i]);
      end
    end
    @(negedge clock);
    n_chk++;
    if ({rsp_valid, rsp_err, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL write_pulse_end: got %b want 001", {rsp_valid, rsp_err, req_ready});
    end
    n_chk++;
    if (address_color !== 10'h123) begin
      n_fail++; $display("FAIL addr_held: got %h want 123", address_color);
    end
  endtask

  task automatic test_read;
    int lat; logic err; logic [3:0] rd;
    resp_val = 4'hA; zw_chk = 0; zw_viol = 0; zwatch = 1'b1;
    run_req(1'b0, 7'h45, 10'h123, 4'h0, lat, err, rd);
    zwatch = 1'b0;
    n_chk++; if (lat != (CACHE ? 4 : 10)) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", lat, CACHE ? 4 : 10); end
    n_chk++; if (rd !== 4'hA) begin n_fail++; $display("FAIL read_data: got %h want a", rd); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b want 0", err); end
    n_chk++; if (zw_chk != 2 || zw_viol != 0) begin n_fail++; $display("FAIL read_access_z: samples %0d drives %0d want 2 0", zw_chk, zw_viol); end
    n_chk++; if (wl_q.size() != (CACHE ? 0 : 2)) begin n_fail++; $display("FAIL read_bus_writes: got %0d want %0d", wl_q.size(), CACHE ? 0 : 2); end
    resp_val = 4'h3;
    run_req(1'b1, 7'h45, 10'h200, 4'h7, lat, err, rd);
    n_chk++; if (rd !== 4'hA) begin n_fail++; $display("FAIL rsp_data_hold: got %h want a", rd); end
    n_chk++; if (lat != (CACHE ? 4 : 10)) begin n_fail++; $display("FAIL hold_latency: got %0d want %0d", lat, CACHE ? 4 : 10); end
  endtask

  task automatic test_back_to_back;
    int lat; logic err; logic [3:0] rd; int n;
    run_req(1'b1, 7'h45, 10'h040, 4'h1, lat, err, rd);
    run_req(1'b1, 7'h45, 10'h041, 4'h2, lat, err, rd);
    n = wl_q.size();
    n_chk++; if (lat != (CACHE ? 4 : 10)) begin n_fail++; $display("FAIL b2b_same_latency: got %0d want %0d", lat, CACHE ? 4 : 10); end
    n_chk++;
    if (n != (CACHE ? 1 : 3) || wl_q[n-1] !== {10'h041, 4'h2}) begin
      n_fail++; $display("FAIL b2b_same_bus: got count %0d last %h want %0d 0412", n, (n > 0) ? wl_q[n-1] : 14'h0, CACHE ? 1 : 3);
    end
    run_req(1'b1, 7'h05, 10'h042, 4'h3, lat, err, rd);
    n = wl_q.size();
    n_chk++; if (lat != (CACHE ? 7 : 10)) begin n_fail++; $display("FAIL b2b_hi_latency: got %0d want %0d", lat, CACHE ? 7 : 10); end
    n_chk++;
    if (n != (CACHE ? 2 : 3) || wl_q[n-2] !== {10'h3FF, 4'h0} || wl_q[n-1] !== {10'h042, 4'h3}) begin
      n_fail++; $display("FAIL b2b_hi_bus: got count %0d want %0d with 3ff0 then 0423", n, CACHE ? 2 : 3);
    end
  endtask

  task automatic test_err;
    int lat; logic err; logic [3:0] rd; int n;
    logic [13:0] exp_w [3];
    exp_w = '{{10'h3FE, 4'h5}, {10'h3FF, 4'h4}, {10'h010, 4'h6}};
    run_req(1'b1, 7'h45, 10'h3FF, 4'h3, lat, err, rd);
    n = wl_q.size();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", err); end
    n_chk++; if (lat != (CACHE ? 7 : 10)) begin n_fail++; $display("FAIL err_latency: got %0d want %0d", lat, CACHE ? 7 : 10); end
    n_chk++; if (n < 1 || wl_q[n-1] !== {10'h3FF, 4'h3}) begin n_fail++; $display("FAIL err_access_done: got count %0d want last 3ff3", n); end
    @(negedge clock);
    n_chk++; if ({rsp_valid, rsp_err} !== 2'b00) begin n_fail++; $display("FAIL err_one_cycle: got %b want 00", {rsp_valid, rsp_err}); end
    run_req(1'b1, 7'h45, 10'h010, 4'h6, lat, err, rd);
    n_chk++; if (lat != 10) begin n_fail++; $display("FAIL after_err_latency: got %0d want 10", lat); end
    n_chk++; if (wl_q.size() != 3) begin n_fail++; $display("FAIL after_err_count: got %0d want 3", wl_q.size()); end
    for (int i = 0; i < 3 && i < wl_q.size(); i++) begin
      n_chk++;
      if (wl_q[i] !== exp_w[i] || !wl_ok[i]) begin
        n_fail++; $display("FAIL after_err_bus[%0d]: got %h ok=%b want %h ok=1", i, wl_q[i], wl_ok[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    int lat; logic err; logic [3:0] rd;
    logic [13:0] exp_w [3];
    exp_w = '{{10'h3FE, 4'hA}, {10'h3FF, 4'h3}, {10'h055, 4'h9}};
    wl_q.delete(); wl_ok.delete();
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_bank = 7'h3A; req_addr = 10'h055; req_data = 4'h9;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
    n_chk++; if ({_we_color, address_color} !== {1'b0, 10'h3FF}) begin n_fail++; $display("FAIL abort_in_hi_strobe: got we=%b a=%h want 0 3ff", _we_color, address_color); end
    _reset = 1'b0;
    #1;
    n_chk++;
    if ({_we_color, _ce_color, phi, data_color, req_ready, rsp_valid} !== {1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL abort_bus_release: got we=%b ce=%b phi=%b d=%h rdy=%b vld=%b want 1 1 0 f 1 0",
                         _we_color, _ce_color, phi, data_color, req_ready, rsp_valid);
    end
    n_chk++; if (wl_q.size() != 1) begin n_fail++; $display("FAIL abort_writes: got %0d want 1", wl_q.size()); end
    @(negedge clock);
    _reset = 1'b1;
    run_req(1'b1, 7'h3A, 10'h055, 4'h9, lat, err, rd);
    n_chk++; if (lat != 10) begin n_fail++; $display("FAIL post_abort_latency: got %0d want 10", lat); end
    n_chk++; if (wl_q.size() != 3) begin n_fail++; $display("FAIL post_abort_count: got %0d want 3", wl_q.size()); end
    for (int i = 0; i < 3 && i < wl_q.size(); i++) begin
      n_chk++;
      if (wl_q[i] !== exp_w[i] || !wl_ok[i]) begin
        n_fail++; $display("FAIL post_abort_bus[%0d]: got %h ok=%b want %h ok=1", i, wl_q[i], wl_ok[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_bus_z;
    n_chk++; if (zi_chk < 20) begin n_fail++; $display("FAIL idle_z_samples: got %0d want >=20", zi_chk); end
    n_chk++; if (zi_viol != 0) begin n_fail++; $display("FAIL idle_z: got %0d driven samples want 0", zi_viol); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_err;
    test_reset_abort;
    test_bus_z;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
